// File: rtl/tdm_codec_if.sv
// -----------------------------------------------------------------------------
// tdm_codec_if
//
// Codec-side 4-slot TDM serial interface running on the 256 x fs system clock.
// It generates the bit clock and the frame clock for the codec. It serialises
// four DAC samples onto sdout and deserialises four ADC samples from sdin.
// Parallel ADC samples are published once per frame together with a one-cycle
// sample_valid strobe.
//
// Frame layout: 256 clk_256fs cycles carry 128 bits, in 4 slots of 32 bits.
// Each sample is MSB first and left-justified in its slot. Slot bits k >= W are
// driven as 0 on sdout and are ignored on sdin.
//
// Parameters:
//   W             sample width in bits, 1..32 (two's complement)
//
// Ports:
//   clk_256fs     in   system clock, 256 x fs
//   rst           in   synchronous active-high reset
//   bick          out  TDM bit clock, clk_256fs / 2
//   lrck          out  frame clock, high for slots 0-1, low for slots 2-3
//   sdout         out  serial DAC data, changes when bick falls
//   sdin          in   serial ADC data, sampled when bick rises
//   sample_in0..3 in   DAC samples for slots 0..3, latched at frame start
//   sample_out0..3 out ADC samples for slots 0..3
//   sample_valid  out  one-cycle strobe, sample_out0..3 updated
//
// Build option:
//   TDM_LOOPBACK_EN  when defined, the deserialiser captures the registered
//                    sdout value instead of sdin. The sdout pin keeps working.
// -----------------------------------------------------------------------------
module tdm_codec_if #(
  parameter int W = 16
) (
  input  logic         clk_256fs,
  input  logic         rst,
  output logic         bick,
  output logic         lrck,
  output logic         sdout,
  input  logic         sdin,
  input  logic [W-1:0] sample_in0,
  input  logic [W-1:0] sample_in1,
  input  logic [W-1:0] sample_in2,
  input  logic [W-1:0] sample_in3,
  output logic [W-1:0] sample_out0,
  output logic [W-1:0] sample_out1,
  output logic [W-1:0] sample_out2,
  output logic [W-1:0] sample_out3,
  output logic         sample_valid
);

  // Frame position: cnt = {slot[1:0], bit_in_slot[4:0], half_bit}
  logic [7:0]   cnt_q;
  logic [1:0]   slot;
  logic [4:0]   bit_k;
  logic         k_in_w;
  logic         wrap;

  logic         bick_q;
  logic         lrck_q;
  logic         sdout_q;
  logic         sdout_d;
  logic         sample_valid_q;
  logic         ser_src;

  logic [W-1:0] sample_in_w    [4];
  logic [W-1:0] dac_shadow_q   [4];
  logic [W-1:0] adc_shift_q    [4];
  logic [W-1:0] adc_shift_d    [4];
  logic [W-1:0] sample_out_q   [4];
  logic [W-1:0] dac_sel;

  assign slot   = cnt_q[7:6];
  assign bit_k  = cnt_q[5:1];
  assign k_in_w = (32'(bit_k) < W);
  assign wrap   = (cnt_q == 8'hFF);

  assign sample_in_w[0] = sample_in0;
  assign sample_in_w[1] = sample_in1;
  assign sample_in_w[2] = sample_in2;
  assign sample_in_w[3] = sample_in3;

  // Shifting left by k brings sample bit W-1-k to the MSB position, which
  // avoids a variable bit index that could go negative for k >= W.
  assign dac_sel = dac_shadow_q[slot] << bit_k;

`ifdef TDM_LOOPBACK_EN
  // sdout_q already holds the current bit by the time bick rises.
  assign ser_src = sdout_q;
`else
  assign ser_src = sdin;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    sdout_d     = 1'b0;
    adc_shift_d = adc_shift_q;
    if (k_in_w) begin
      sdout_d = dac_sel[W-1];
    end
    // Odd cnt is the edge that drives bick 0->1, which is where sdin is sampled.
    if (cnt_q[0] && k_in_w) begin
      adc_shift_d[slot] = (adc_shift_q[slot] << 1) | W'(ser_src);
    end
  end

  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      cnt_q          <= 8'd0;
      bick_q         <= 1'b0;
      lrck_q         <= 1'b0;
      sdout_q        <= 1'b0;
      sample_valid_q <= 1'b0;
      // NOTE: these small register arrays are reset on purpose. A reset in the
      // middle of a frame must discard both the partial frame and old samples.
      for (int i = 0; i < 4; i++) begin
        dac_shadow_q[i] <= '0;
        adc_shift_q[i]  <= '0;
        sample_out_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here sees the pre-edge value of cnt_q.
      cnt_q          <= cnt_q + 8'd1;
      bick_q         <= cnt_q[0];
      lrck_q         <= ~cnt_q[7];
      sample_valid_q <= wrap;
      adc_shift_q    <= adc_shift_d;
      // Even cnt drives bick 1->0. sdout only moves on that edge.
      if (!cnt_q[0]) begin
        sdout_q <= sdout_d;
      end
      // The wrap edge also samples bit 127. Publishing adc_shift_d keeps that
      // bit in this frame's result when W = 32.
      if (wrap) begin
        dac_shadow_q <= sample_in_w;
        sample_out_q <= adc_shift_d;
      end
    end
  end

  assign bick         = bick_q;
  assign lrck         = lrck_q;
  assign sdout        = sdout_q;
  assign sample_valid = sample_valid_q;
  assign sample_out0  = sample_out_q[0];
  assign sample_out1  = sample_out_q[1];
  assign sample_out2  = sample_out_q[2];
  assign sample_out3  = sample_out_q[3];

endmodule
